mux_rr_arbiter: RTL and testbench

//  Shares the 8-bit 2:1 select datapath (m = s ? y : x) between two streaming

---
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 select datapath between streaming requesters X and Y,
// with bounded bursts and a one-entry valid/ready output register toward the sink.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             s,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_X,
        OWN_Y
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;   // 0 = X served last, 1 = Y served last
    logic             s_q, s_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;

    logic             out_free;
    logic             beat;
    logic             own_valid;
    logic             other_valid;
    logic             own_is_y;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            s_q       <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Next-state, burst accounting and output-register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        own_is_y    = (state_q == OWN_Y);
        own_valid   = own_is_y ? y_valid : x_valid;
        other_valid = own_is_y ? x_valid : y_valid;
        beat        = (x_valid & x_ready) | (y_valid & y_ready);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (x_valid && y_valid) begin
                    state_d = last_q ? OWN_X : OWN_Y;
                end else if (x_valid) begin
                    state_d = OWN_X;
                end else if (y_valid) begin
                    state_d = OWN_Y;
                end
            end
            OWN_X, OWN_Y: begin
                if (beat && cnt_q == BURST_LAST) begin
                    cnt_d  = '0;
                    last_d = own_is_y;
                    if (other_valid) begin
                        state_d = own_is_y ? OWN_X : OWN_Y;
                    end
                end else if (!own_valid) begin
                    cnt_d   = '0;
                    last_d  = own_is_y;
                    state_d = other_valid ? (own_is_y ? OWN_X : OWN_Y) : IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // s follows the next owner and holds through IDLE
        case (state_d)
            OWN_X:   s_d = 1'b0;
            OWN_Y:   s_d = 1'b1;
            default: s_d = s_q;
        endcase

        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (beat) begin
            m_data_d  = own_is_y ? y_data : x_data;
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        out_free = ~m_valid_q | m_ready;
        x_ready  = (state_q == OWN_X) & out_free;
        y_ready  = (state_q == OWN_Y) & out_free;
        s        = s_q;
        m_valid  = m_valid_q;
        m_data   = m_data_q;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: bubble, burst alternation, stall, early release,
// asynchronous reset and round-robin fairness, all with hand-computed expectations.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x_valid = 1'b0;
    logic [7:0] x_data = '0;
    logic       x_ready;
    logic       y_valid = 1'b0;
    logic [7:0] y_data = '0;
    logic       y_ready;
    logic       s;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_valid (x_valid),
        .x_data  (x_data),
        .x_ready (x_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .s       (s),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven at the falling edge; one call advances one rising edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_m_data",  32'(m_data),  0);
        check_eq("rst_s",       32'(s),       0);
        check_eq("rst_x_ready", 32'(x_ready), 0);
        check_eq("rst_y_ready", 32'(y_ready), 0);

        // T1: only X, one arbitration bubble then back-to-back words
        rst_n   = 1'b1;
        m_ready = 1'b1;
        x_valid = 1'b1;
        x_data  = 8'h11;
        #1 check_eq("t1_idle_x_ready", 32'(x_ready), 0);
        cyc();
        check_eq("t1_bubble_m_valid", 32'(m_valid), 0);
        check_eq("t1_s", 32'(s), 0);
        for (int i = 0; i < 3; i++) begin
            x_data = 8'(8'h11 * (i + 1));
            #1 check_eq("t1_x_ready", 32'(x_ready), 1);
            cyc();
            check_eq("t1_m_valid", 32'(m_valid), 1);
            check_eq("t1_m_data",  32'(m_data),  32'(8'h11 * (i + 1)));
            check_eq("t1_s_beat",  32'(s), 0);
        end
        x_valid = 1'b0;
        cyc();
        check_eq("t1_drain_m_valid", 32'(m_valid), 0);

        // T2: both valid; last served was X, so Y is granted first
        x_valid = 1'b1;
        x_data  = 8'hAA;
        y_valid = 1'b1;
        y_data  = 8'h55;
        #1 check_eq("t2_idle_ready", 32'({x_ready, y_ready}), 0);
        cyc();
        check_eq("t2_bubble_m_valid", 32'(m_valid), 0);
        for (int i = 0; i < 16; i++) begin
            automatic logic own_y = ((i / 4) % 2) == 0;
            #1 check_eq("t2_s", 32'(s), 32'(own_y));
            check_eq("t2_ready", 32'({x_ready, y_ready}), own_y ? 32'b01 : 32'b10);
            cyc();
            check_eq("t2_m_valid", 32'(m_valid), 1);
            check_eq("t2_m_data", 32'(m_data), own_y ? 32'h55 : 32'hAA);
        end

        // T3: stall with held word, then release; Y still gets a full 4-beat burst
        m_ready = 1'b0;
        y_data  = 8'h77;
        #1 check_eq("t3_stall_y_ready", 32'(y_ready), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("t3_hold_m_data",  32'(m_data),  32'hAA);
            check_eq("t3_hold_m_valid", 32'(m_valid), 1);
            check_eq("t3_hold_y_ready", 32'(y_ready), 0);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            y_data = 8'(8'h77 + i);
            #1 check_eq("t3_y_ready", 32'(y_ready), 1);
            check_eq("t3_s", 32'(s), 1);
            cyc();
            check_eq("t3_m_data", 32'(m_data), 32'(8'h77 + i));
        end
        #1 check_eq("t3_switch_s", 32'(s), 0);
        check_eq("t3_switch_x_ready", 32'(x_ready), 1);

        // T4: X releases after 2 beats, Y takes over directly with a fresh burst
        x_data = 8'h31;
        cyc();
        check_eq("t4_m_data0", 32'(m_data), 32'h31);
        x_data = 8'h32;
        cyc();
        check_eq("t4_m_data1", 32'(m_data), 32'h32);
        x_valid = 1'b0;
        y_data  = 8'h61;
        cyc();
        check_eq("t4_release_s",       32'(s),       1);
        check_eq("t4_release_m_valid", 32'(m_valid), 0);
        for (int i = 0; i < 4; i++) begin
            y_data = 8'(8'h61 + i);
            #1 check_eq("t4_y_ready", 32'(y_ready), 1);
            cyc();
            check_eq("t4_m_data", 32'(m_data), 32'(8'h61 + i));
            check_eq("t4_s", 32'(s), 1);
        end
        #1 check_eq("t4_stay_y_ready", 32'(y_ready), 1);

        // T5: asynchronous reset in the middle of a Y burst
        y_data = 8'h65;
        cyc();
        y_data = 8'h66;
        cyc();
        check_eq("t5_pre_m_data", 32'(m_data), 32'h66);
        #2 rst_n = 1'b0;
        #1 check_eq("t5_m_valid", 32'(m_valid), 0);
        check_eq("t5_m_data", 32'(m_data), 0);
        check_eq("t5_s",      32'(s),      0);
        check_eq("t5_ready",  32'({x_ready, y_ready}), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        x_valid = 1'b1;
        x_data  = 8'h91;
        y_valid = 1'b1;
        #1 check_eq("t5_idle_ready", 32'({x_ready, y_ready}), 0);
        cyc();
        check_eq("t5_grant_s", 32'(s), 0);
        check_eq("t5_grant_ready", 32'({x_ready, y_ready}), 32'b10);
        cyc();
        check_eq("t5_m_data", 32'(m_data), 32'h91);

        // T6: Y served last, then both request together -> X wins
        x_valid = 1'b0;
        cyc();
        check_eq("t6_own_y_s", 32'(s), 1);
        y_data = 8'hC1;
        cyc();
        check_eq("t6_m_data", 32'(m_data), 32'hC1);
        y_valid = 1'b0;
        cyc();
        cyc();
        check_eq("t6_idle_s",     32'(s), 1);
        check_eq("t6_idle_ready", 32'({x_ready, y_ready}), 0);
        x_valid = 1'b1;
        y_valid = 1'b1;
        cyc();
        check_eq("t6_grant_s", 32'(s), 0);
        check_eq("t6_grant_ready", 32'({x_ready, y_ready}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
